// File: rtl/vt52_pkg.sv
// Constants and types shared by the VT52 character display path.
package vt52_pkg;

  localparam int ROWS          = 25;
  localparam int COLS          = 80;
  localparam int PAST_LAST_ROW = ROWS * COLS;

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_DEL   = 8'h7F;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_LINE,
    CLEAR_SCREEN
  } writer_state_t;

endpackage

// File: rtl/char_buffer_writer_if.sv
// Byte-stream valid/ready handshake feeding the character buffer writer.
interface char_buffer_writer_if;

  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_in, output char_valid, input char_ready);
  modport slave  (input char_in, input char_valid, output char_ready);

endinterface

// File: rtl/char_addr_wrap.sv
// Combinational adder modulo PAST_LAST_ROW; both operands must already be < PAST_LAST_ROW.
module char_addr_wrap #(
  parameter int ADDR_BITS     = 11,
  parameter int PAST_LAST_ROW = 2000
) (
  input  logic [ADDR_BITS-1:0] a,
  input  logic [ADDR_BITS-1:0] b,
  output logic [ADDR_BITS-1:0] sum
);

  logic [ADDR_BITS:0] raw;
  logic [ADDR_BITS:0] wrapped;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    if (raw >= (ADDR_BITS+1)'(PAST_LAST_ROW)) begin
      wrapped = raw - (ADDR_BITS+1)'(PAST_LAST_ROW);
    end else begin
      wrapped = raw;
    end
    sum = wrapped[ADDR_BITS-1:0];
  end

endmodule

// File: rtl/char_buffer_writer.sv
// Write side of the 80x25 text buffer: cursor tracking, CR/LF/BS handling and pointer scrolling.
// Build option CHAR_BUFFER_WRITER_CLEAR_ON_RESET_EN blanks the whole buffer after reset.
module char_buffer_writer #(
  parameter int ROWS          = vt52_pkg::ROWS,
  parameter int COLS          = vt52_pkg::COLS,
  parameter int ROW_BITS      = 5,
  parameter int COL_BITS      = 7,
  parameter int ADDR_BITS     = 11,
  parameter int PAST_LAST_ROW = ROWS * COLS
) (
  input  logic                 clk,
  input  logic                 clr,
  char_buffer_writer_if.slave  char_bus,
  output logic [ROW_BITS-1:0]  cursor_row,
  output logic [COL_BITS-1:0]  cursor_col,
  output logic [ADDR_BITS-1:0] buffer_waddr,
  output logic [7:0]           buffer_din,
  output logic                 buffer_wen,
  output logic [ADDR_BITS-1:0] buffer_first_char,
  output logic                 buffer_first_char_wen
);

  import vt52_pkg::*;

`ifdef CHAR_BUFFER_WRITER_CLEAR_ON_RESET_EN
  localparam writer_state_t RESET_STATE = CLEAR_SCREEN;
`else
  localparam writer_state_t RESET_STATE = IDLE;
`endif

  writer_state_t        state, next_state;
  logic [ADDR_BITS-1:0] line_base, next_line_base;
  logic [ADDR_BITS-1:0] clear_addr, next_clear_addr;
  logic [ADDR_BITS-1:0] clear_cnt, next_clear_cnt;
  logic [ADDR_BITS-1:0] clear_last;
  logic [ROW_BITS-1:0]  next_row;
  logic [COL_BITS-1:0]  next_col;
  logic [ADDR_BITS-1:0] next_waddr;
  logic [7:0]           next_din;
  logic                 next_wen;
  logic [ADDR_BITS-1:0] next_first_char;
  logic                 next_first_char_wen;

  logic [ADDR_BITS-1:0] cursor_addr, line_base_down, first_char_down, clear_addr_inc;
  logic                 printable;

  char_addr_wrap #(.ADDR_BITS(ADDR_BITS), .PAST_LAST_ROW(PAST_LAST_ROW)) u_cursor_addr (
    .a(line_base), .b(ADDR_BITS'(cursor_col)), .sum(cursor_addr)
  );
  char_addr_wrap #(.ADDR_BITS(ADDR_BITS), .PAST_LAST_ROW(PAST_LAST_ROW)) u_line_down (
    .a(line_base), .b(ADDR_BITS'(COLS)), .sum(line_base_down)
  );
  char_addr_wrap #(.ADDR_BITS(ADDR_BITS), .PAST_LAST_ROW(PAST_LAST_ROW)) u_first_down (
    .a(buffer_first_char), .b(ADDR_BITS'(COLS)), .sum(first_char_down)
  );
  char_addr_wrap #(.ADDR_BITS(ADDR_BITS), .PAST_LAST_ROW(PAST_LAST_ROW)) u_clear_inc (
    .a(clear_addr), .b(ADDR_BITS'(1)), .sum(clear_addr_inc)
  );

  assign char_bus.char_ready = (state == IDLE);
  assign printable  = (char_bus.char_in >= CHAR_SPACE) && (char_bus.char_in < CHAR_DEL);
  assign clear_last = (state == CLEAR_LINE) ? ADDR_BITS'(COLS - 1) : ADDR_BITS'(PAST_LAST_ROW - 1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state                 <= RESET_STATE;
      cursor_row            <= '0;
      cursor_col            <= '0;
      line_base             <= '0;
      clear_addr            <= '0;
      clear_cnt             <= '0;
      buffer_waddr          <= '0;
      buffer_din            <= '0;
      buffer_wen            <= 1'b0;
      buffer_first_char     <= '0;
      buffer_first_char_wen <= 1'b0;
    end else begin
      state                 <= next_state;
      cursor_row            <= next_row;
      cursor_col            <= next_col;
      line_base             <= next_line_base;
      clear_addr            <= next_clear_addr;
      clear_cnt             <= next_clear_cnt;
      buffer_waddr          <= next_waddr;
      buffer_din            <= next_din;
      buffer_wen            <= next_wen;
      buffer_first_char     <= next_first_char;
      buffer_first_char_wen <= next_first_char_wen;
    end
  end

  always_comb begin
    next_state          = state;
    next_row            = cursor_row;
    next_col            = cursor_col;
    next_line_base      = line_base;
    next_clear_addr     = clear_addr;
    next_clear_cnt      = clear_cnt;
    next_waddr          = buffer_waddr;
    next_din            = buffer_din;
    next_wen            = 1'b0;
    next_first_char     = buffer_first_char;
    next_first_char_wen = 1'b0;

    unique case (state)
      IDLE: begin
        if (char_bus.char_valid) begin
          if (printable) begin
            next_wen   = 1'b1;
            next_waddr = cursor_addr;
            next_din   = char_bus.char_in;
            if (cursor_col != COL_BITS'(COLS - 1)) next_col = cursor_col + 1'b1;
          end else if (char_bus.char_in == CHAR_CR) begin
            next_col = '0;
          end else if (char_bus.char_in == CHAR_BS) begin
            if (cursor_col != '0) next_col = cursor_col - 1'b1;
          end else if (char_bus.char_in == CHAR_LF) begin
            if (cursor_row != ROW_BITS'(ROWS - 1)) begin
              next_row       = cursor_row + 1'b1;
              next_line_base = line_base_down;
            end else begin
              // Old top line is recycled as the new bottom row; blank it after the pointer moves.
              next_first_char     = first_char_down;
              next_first_char_wen = 1'b1;
              next_line_base      = buffer_first_char;
              next_clear_addr     = buffer_first_char;
              next_clear_cnt      = '0;
              next_state          = CLEAR_LINE;
            end
          end
        end
      end
      CLEAR_LINE, CLEAR_SCREEN: begin
        next_wen        = 1'b1;
        next_waddr      = clear_addr;
        next_din        = CHAR_SPACE;
        next_clear_addr = clear_addr_inc;
        next_clear_cnt  = clear_cnt + 1'b1;
        if (clear_cnt == clear_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_char_buffer_writer.sv
// Directed bench for char_buffer_writer with a write scoreboard fed by a cursor/pointer model.
module tb_char_buffer_writer;

  localparam int T_ROWS = 25;
  localparam int T_COLS = 80;
  localparam int T_SIZE = 2000;

`ifdef CHAR_BUFFER_WRITER_CLEAR_ON_RESET_EN
  localparam logic READY_AT_RESET = 1'b0;
`else
  localparam logic READY_AT_RESET = 1'b1;
`endif

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk;
  logic        clr;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic [10:0] buffer_waddr;
  logic [7:0]  buffer_din;
  logic        buffer_wen;
  logic [10:0] buffer_first_char;
  logic        buffer_first_char_wen;

  char_buffer_writer_if cbus ();

  char_buffer_writer dut (
    .clk                  (clk),
    .clr                  (clr),
    .char_bus             (cbus),
    .cursor_row           (cursor_row),
    .cursor_col           (cursor_col),
    .buffer_waddr         (buffer_waddr),
    .buffer_din           (buffer_din),
    .buffer_wen           (buffer_wen),
    .buffer_first_char    (buffer_first_char),
    .buffer_first_char_wen(buffer_first_char_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  int  m_row, m_col, m_fc;
  int  exp_fc;
  bit  fc_pending;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_fc = 0; fc_pending = 1'b0; exp_fc = 0;
    exp_q.delete();
  endtask

  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (buffer_wen === 1'b1) begin
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("waddr", 32'(buffer_waddr), 32'(e.addr));
        check("wdata", 32'(buffer_din), 32'(e.data));
      end
    end
    if (buffer_first_char_wen === 1'b1) begin
      check("first_char_wen_expected", 32'(fc_pending), 32'd1);
      check("first_char", 32'(buffer_first_char), 32'(exp_fc));
      fc_pending = 1'b0;
    end
  endtask

  task automatic check_reset_values();
    check("rst_row",     32'(cursor_row), 32'd0);
    check("rst_col",     32'(cursor_col), 32'd0);
    check("rst_waddr",   32'(buffer_waddr), 32'd0);
    check("rst_din",     32'(buffer_din), 32'd0);
    check("rst_wen",     32'(buffer_wen), 32'd0);
    check("rst_fc",      32'(buffer_first_char), 32'd0);
    check("rst_fc_wen",  32'(buffer_first_char_wen), 32'd0);
    check("rst_ready",   32'(cbus.char_ready), 32'(READY_AT_RESET));
  endtask

  task automatic release_reset();
    int waited;
    tick();
    clr = 1'b0;
`ifdef CHAR_BUFFER_WRITER_CLEAR_ON_RESET_EN
    for (int i = 0; i < T_SIZE; i++) exp_q.push_back('{addr: 11'(i), data: 8'h20});
    waited = 0;
    while (cbus.char_ready !== 1'b1 && waited < T_SIZE + 200) begin
      waited++;
      tick();
    end
    check("screen_clear_pending", 32'(exp_q.size()), 32'd0);
`else
    waited = 0;
    tick();
    check("wen_after_reset", 32'(buffer_wen), 32'd0);
`endif
    check("ready_after_reset", 32'(cbus.char_ready), 32'd1);
  endtask

  task automatic pulse_reset();
    clr = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    release_reset();
  endtask

  // Updates the model for one accepted byte and queues the writes it should cause.
  task automatic model_byte(input logic [7:0] b, output bit scroll);
    int a;
    scroll = 1'b0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      a = (m_fc + m_row * T_COLS + m_col) % T_SIZE;
      exp_q.push_back('{addr: 11'(a), data: b});
      if (m_col < T_COLS - 1) m_col++;
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0A) begin
      if (m_row < T_ROWS - 1) begin
        m_row++;
      end else begin
        scroll     = 1'b1;
        exp_fc     = (m_fc + T_COLS) % T_SIZE;
        fc_pending = 1'b1;
        for (int i = 0; i < T_COLS; i++)
          exp_q.push_back('{addr: 11'((m_fc + i) % T_SIZE), data: 8'h20});
        m_fc = exp_fc;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit scroll;
    int low;
    check("ready_before_send", 32'(cbus.char_ready), 32'd1);
    cbus.char_in    = b;
    cbus.char_valid = 1'b1;
    model_byte(b, scroll);
    tick();
    cbus.char_valid = 1'b0;
    if (scroll) begin
      low = 0;
      while (cbus.char_ready !== 1'b1 && low < 300) begin
        low++;
        tick();
      end
      check("clear_ready_low_cycles", 32'(low), 32'(T_COLS));
      check("first_char_pulse_seen", 32'(fc_pending), 32'd0);
      check("first_char_hold", 32'(buffer_first_char), 32'(m_fc));
    end
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, 32'(cursor_row), 32'(m_row));
    check({tag, "_col"}, 32'(cursor_col), 32'(m_col));
  endtask

  initial begin
    bit scroll;
    logic [7:0] b;
    clr = 1'b1;
    cbus.char_in = 8'h00;
    cbus.char_valid = 1'b0;
    model_reset();
    tick();
    pulse_reset();

    // single printable
    send(8'h41);
    check_cursor("after_A");
    check("ready_after_A", 32'(cbus.char_ready), 32'd1);

    // CR LF printable back-to-back
    send(8'h0D);
    send(8'h0A);
    send(8'h42);
    check_cursor("after_crlf_B");
    check("row1_col1_row", 32'(cursor_row), 32'd1);

    // column saturation and ignored bytes
    pulse_reset();
    for (int i = 0; i < 82; i++) begin
      b = (i == 0) ? 8'h20 : (i == 81) ? 8'h7E : 8'(8'h30 + (i % 64));
      send(b);
    end
    check("col_saturated", 32'(cursor_col), 32'd79);
    send(8'h7F);
    send(8'h00);
    send(8'h1B);
    check_cursor("ignored_bytes");

    // backspace to column 0 and beyond
    for (int i = 0; i < 80; i++) send(8'h08);
    check("bs_to_zero", 32'(cursor_col), 32'd0);
    send(8'h08);
    check_cursor("bs_at_zero");

    // walk to the bottom row, then scroll once
    send(8'h0D);
    for (int i = 0; i < 24; i++) send(8'h0A);
    check("bottom_row", 32'(cursor_row), 32'd24);
    send(8'h0A);
    check("first_scroll_fc", 32'(buffer_first_char), 32'd80);
    check_cursor("after_first_scroll");
    send(8'h43);
    check_cursor("after_C");

    // scroll until the top pointer wraps around the buffer
    for (int i = 0; i < 23; i++) send(8'h0A);
    check("fc_before_wrap", 32'(buffer_first_char), 32'd1920);
    send(8'h0A);
    check("fc_wrapped", 32'(buffer_first_char), 32'd0);
    send(8'h0D);
    for (int i = 0; i < 5; i++) send(8'h20);
    check("col5", 32'(cursor_col), 32'd5);
    send(8'h44);
    check_cursor("after_D");

    // reset in the middle of a line clear
    check("ready_before_abort", 32'(cbus.char_ready), 32'd1);
    cbus.char_in    = 8'h0A;
    cbus.char_valid = 1'b1;
    model_byte(8'h0A, scroll);
    tick();
    cbus.char_valid = 1'b0;
    check("abort_scroll_started", 32'(scroll), 32'd1);
    for (int i = 0; i < 40; i++) tick();
    check("abort_mid_clear_ready", 32'(cbus.char_ready), 32'd0);
    clr = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    release_reset();
    send(8'h5A);
    check_cursor("after_abort_Z");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
